// File: rtl/accel_feeder.sv
// ---------------------------------------------------------------------------------------------
// accel_feeder
//
// Streams COUNT 32-bit words from memory (byte address SRC, stride 4, wraps modulo 2^32) into a
// write-only accelerator data port. It then reads one result word back from the accelerator
// and exposes it to the CPU through a small CSR block.
//
// Per job:
//   1. Arm/clear the accelerator.
//   2. For each element: fetch the word from memory, then push it to the accelerator.
//   3. Read the result from the accelerator.
//
// Parameters
//   GAP     minimum clk cycles from one accelerator data write to the next accelerator access.
//           Values below 2 behave as 2.
//   RD_LAT  cycles from the accelerator read strobe to valid a_readdata (>= 1).
//
// Ports
//   clk, reset_n          single rising-edge clock, asynchronous active-low reset
//   s_*                   CPU CSR slave: 0=SRC, 1=COUNT[15:0], 2=CTRL/STATUS, 3=RESULT (RO)
//                         s_readdata is registered; it is valid one cycle after s_read.
//   m_*                   memory read master (waitrequest / readdatavalid handshake)
//   a_*                   accelerator master: a_address 0 = data x, 1 = arm/clear
//   irq                   only with FEEDER_IRQ_EN defined; irq = done & irq-enable
//
// CTRL write bits
//   bit0  start (accepted only while not busy)
//   bit1  clear done
//   bit2  irq enable (FEEDER_IRQ_EN only)
//
// STATUS read
//   {29'b0, irq_en, done, busy}
//
// Optional feature macro: FEEDER_IRQ_EN.
// ---------------------------------------------------------------------------------------------
`timescale 1ns / 1ps

module accel_feeder #(
    parameter int unsigned GAP    = 10,
    parameter int unsigned RD_LAT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    // CPU CSR slave
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    // Memory read master
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    // Accelerator master
`ifdef FEEDER_IRQ_EN
    output logic        irq,
`endif
    output logic        a_address,
    output logic        a_write,
    output logic [31:0] a_writedata,
    output logic        a_read,
    input  logic [31:0] a_readdata
);

    localparam logic [1:0] AddrSrc    = 2'd0;
    localparam logic [1:0] AddrCount  = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrResult = 2'd3;

    // The gap counter is loaded on PUSH and counts down to 0, so the load value is GAP-2.
    localparam logic [31:0] GapLoad = (GAP >= 2) ? 32'(GAP - 2) : 32'd0;
    localparam logic [31:0] RdLoad  = (RD_LAT >= 1) ? 32'(RD_LAT - 1) : 32'd0;

    typedef enum logic [3:0] {
        StIdle,
        StArm,
        StFetch,
        StWaitData,
        StPush,
        StGap,
        StReadRes,
        StWaitRes,
        StDone
    } state_e;

    state_e      r_state;
    logic [31:0] r_src;
    logic [15:0] r_count;
    logic [31:0] r_result;
    logic        r_busy;
    logic        r_done;
    logic        r_irq_en;
    logic [31:0] r_addr;       // address of the next element to fetch
    logic [15:0] r_idx;        // number of elements already pushed
    logic [31:0] r_cnt;        // shared down-counter for GAP and WAIT_RES
    logic [31:0] r_s_readdata;
    logic [31:0] r_m_address;
    logic        r_m_read;
    logic        r_a_address;
    logic        r_a_write;
    logic [31:0] r_a_writedata;
    logic        r_a_read;

    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_clear;
    logic [31:0] w_status;

    assign w_ctrl_wr = s_write && (s_address == AddrCtrl);
    assign w_start   = w_ctrl_wr && s_writedata[0] && !r_busy;
    assign w_clear   = w_ctrl_wr && s_writedata[1];

    always_comb begin
        w_status    = 32'b0;
        w_status[0] = r_busy;
        w_status[1] = r_done;
`ifdef FEEDER_IRQ_EN
        w_status[2] = r_irq_en;
`endif
    end

    // Main controller: CSR state and the job FSM share one process, because busy/done are
    // written both by CPU writes and by the sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_src         <= 32'b0;
            r_count       <= 16'b0;
            r_result      <= 32'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_irq_en      <= 1'b0;
            r_addr        <= 32'b0;
            r_idx         <= 16'b0;
            r_cnt         <= 32'b0;
            r_m_address   <= 32'b0;
            r_m_read      <= 1'b0;
            r_a_address   <= 1'b0;
            r_a_write     <= 1'b0;
            r_a_writedata <= 32'b0;
            r_a_read      <= 1'b0;
        end else begin
            // Job configuration is frozen while a job runs.
            if (s_write && !r_busy) begin
                if (s_address == AddrSrc) begin
                    r_src <= s_writedata;
                end
                if (s_address == AddrCount) begin
                    r_count <= s_writedata[15:0];
                end
            end
`ifdef FEEDER_IRQ_EN
            if (w_ctrl_wr) begin
                r_irq_en <= s_writedata[2];
            end
`endif
            if (w_clear) begin
                r_done <= 1'b0;
            end

            case (r_state)
                StIdle, StDone: begin
                    r_state <= StIdle;
                    if (w_start) begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_addr  <= r_src;
                        r_idx   <= 16'b0;
                        r_state <= StArm;
                        // An empty job passes through ARM without touching the accelerator.
                        if (r_count != 16'b0) begin
                            r_a_write     <= 1'b1;
                            r_a_address   <= 1'b1;
                            r_a_writedata <= 32'b0;
                        end
                    end
                end
                StArm: begin
                    r_a_write <= 1'b0;
                    if (r_count == 16'b0) begin
                        r_result <= 32'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_m_read    <= 1'b1;
                        r_m_address <= r_addr;
                        r_state     <= StFetch;
                    end
                end
                StFetch: begin
                    if (!m_waitrequest) begin
                        r_m_read <= 1'b0;
                        r_state  <= StWaitData;
                    end
                end
                StWaitData: begin
                    if (m_readdatavalid) begin
                        r_a_write     <= 1'b1;
                        r_a_address   <= 1'b0;
                        r_a_writedata <= m_readdata;
                        r_state       <= StPush;
                    end
                end
                StPush: begin
                    r_a_write <= 1'b0;
                    r_idx     <= r_idx + 16'd1;
                    r_addr    <= r_addr + 32'd4;
                    r_cnt     <= GapLoad;
                    r_state   <= StGap;
                end
                StGap: begin
                    if (r_cnt == 32'b0) begin
                        if (r_idx == r_count) begin
                            r_a_read <= 1'b1;
                            r_state  <= StReadRes;
                        end else begin
                            r_m_read    <= 1'b1;
                            r_m_address <= r_addr;
                            r_state     <= StFetch;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                StReadRes: begin
                    r_a_read <= 1'b0;
                    r_cnt    <= RdLoad;
                    r_state  <= StWaitRes;
                end
                StWaitRes: begin
                    // The counter reaches 0 in the cycle exactly RD_LAT after the strobe.
                    if (r_cnt == 32'b0) begin
                        r_result <= a_readdata;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Registered CSR read port: the value appears the cycle after s_read and is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_readdata <= 32'b0;
        end else if (s_read) begin
            case (s_address)
                AddrSrc:    r_s_readdata <= r_src;
                AddrCount:  r_s_readdata <= {16'b0, r_count};
                AddrCtrl:   r_s_readdata <= w_status;
                AddrResult: r_s_readdata <= r_result;
                default:    r_s_readdata <= 32'b0;
            endcase
        end
    end

    assign s_readdata  = r_s_readdata;
    assign m_address   = r_m_address;
    assign m_read      = r_m_read;
    assign a_address   = r_a_address;
    assign a_write     = r_a_write;
    assign a_writedata = r_a_writedata;
    assign a_read      = r_a_read;
`ifdef FEEDER_IRQ_EN
    assign irq         = r_done & r_irq_en;
`endif

endmodule

// File: tb/tb_accel_feeder.sv
// ---------------------------------------------------------------------------------------------
// tb_accel_feeder
//
// Scoreboard bench for accel_feeder.
//
// Stimulus
//   Each job pushes its expected transactions into queues before the job starts:
//     - memory read addresses
//     - accelerator writes
//     - the a_read count
//     - CSR read values
//   A negedge monitor pops those queues and compares whenever the DUT shows a strobe.
//
// Models
//   Memory   a hash of the address, with per-address overrides. Its latency and waitrequest
//            stalls are random, and it raises spurious readdatavalid pulses while no read is
//            outstanding.
//   Accel    a stub that sums the data words written since the last arm. It presents
//            sum ^ KEY only in the cycle exactly RD_LAT after the a_read strobe, and random
//            data otherwise.
// ---------------------------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_accel_feeder;

    localparam int unsigned GAP    = 10;
    localparam int unsigned RD_LAT = 10;
    localparam logic [31:0] KEY    = 32'h5A5A_0F0F;

    logic        clk;
    logic        reset_n;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        a_address;
    logic        a_write;
    logic [31:0] a_writedata;
    logic        a_read;
    logic [31:0] a_readdata;
`ifdef FEEDER_IRQ_EN
    logic        irq;
`endif

    accel_feeder #(
        .GAP    (GAP),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_readdata      (s_readdata),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
`ifdef FEEDER_IRQ_EN
        .irq             (irq),
`endif
        .a_address       (a_address),
        .a_write         (a_write),
        .a_writedata     (a_writedata),
        .a_read          (a_read),
        .a_readdata      (a_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model state ----------------
    typedef struct packed {
        logic        addr;
        logic [31:0] data;
    } aw_t;

    aw_t         exp_aw[$];
    logic [31:0] exp_maddr[$];
    logic [31:0] exp_rd[$];
    int          exp_aread = 0;
    logic [31:0] mem_over[logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    stall_cfg  = 0;   // < 0 selects a random stall per read
    int    stall_left = 0;
    bit    in_read    = 1'b0;
    bit    spur_en    = 1'b0;

    initial begin
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = 32'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                pend.delete();
                in_read         = 1'b0;
                m_waitrequest   = 1'b0;
                m_readdatavalid = 1'b0;
            end else begin
                if (m_read) begin
                    if (!in_read) begin
                        in_read    = 1'b1;
                        stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 4)) : stall_cfg;
                    end
                    if (stall_left > 0) begin
                        m_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        m_waitrequest = 1'b0;
                        pend.push_back('{m_address, cyc + int'($urandom_range(1, 3))});
                        in_read = 1'b0;
                    end
                end else begin
                    m_waitrequest = 1'($urandom_range(0, 1));
                end
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    m_readdatavalid = 1'b1;
                    m_readdata      = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    // Spurious valids appear only while no read is outstanding.
                    m_readdatavalid = (pend.size() == 0) && spur_en && ($urandom_range(0, 7) == 0);
                    m_readdata      = $urandom;
                end
            end
        end
    end

    // ---------------- accelerator stub ----------------
    logic [31:0] acc    = 32'b0;
    int          due_rd = -100;

    initial begin
        a_readdata = 32'b0;
        forever begin
            @(posedge clk);
            #1;
            a_readdata = (cyc == due_rd) ? (acc ^ KEY) : $urandom;
        end
    end

    // ---------------- monitor ----------------
    bit          rd_pend    = 1'b0;
    bit          prev_stall = 1'b0;
    bit          have_last  = 1'b0;
    int          last_data  = 0;
    int          n_data_wr  = 0;
    logic [31:0] held_addr  = 32'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rd_pend    = 1'b0;
            prev_stall = 1'b0;
            have_last  = 1'b0;
        end else begin
            if (rd_pend) begin
                if (exp_rd.size() == 0) fail_now("unexpected_csr_read");
                else check("csr_readdata", s_readdata, exp_rd.pop_front());
            end
            rd_pend = s_read;

            if (a_write && a_read) fail_now("a_write_and_a_read_together");

            if ((a_write || a_read) && have_last) begin
                n_checks++;
                if (cyc - last_data < int'(GAP)) begin
                    n_errors++;
                    $display("FAIL gap_spacing: got %0d cycles, required >= %0d",
                             cyc - last_data, GAP);
                end
            end

            if (a_write) begin
                if (exp_aw.size() == 0) begin
                    fail_now("unexpected_a_write");
                end else begin
                    aw_t e;
                    e = exp_aw.pop_front();
                    check("a_address", 32'(a_address), 32'(e.addr));
                    check("a_writedata", a_writedata, e.data);
                end
                if (a_address == 1'b0) begin
                    acc       = acc + a_writedata;
                    last_data = cyc;
                    have_last = 1'b1;
                    n_data_wr++;
                end else begin
                    acc = 32'b0;
                end
            end

            if (a_read) begin
                if (exp_aread == 0) fail_now("unexpected_a_read");
                else exp_aread--;
                due_rd = cyc + int'(RD_LAT);
            end

            if (m_read) begin
                if (prev_stall) begin
                    check("m_address_stable", m_address, held_addr);
                end else if (exp_maddr.size() == 0) begin
                    fail_now("unexpected_m_read");
                end else begin
                    check("m_address", m_address, exp_maddr.pop_front());
                    held_addr = m_address;
                end
            end else if (prev_stall) begin
                fail_now("m_read_dropped_during_stall");
            end
            prev_stall = m_read && m_waitrequest;
        end
    end

    // ---------------- stimulus ----------------
    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        s_write     = 1'b1;
        s_address   = a;
        s_writedata = d;
        @(posedge clk);
        #1;
        s_write = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1;
        s_read    = 1'b1;
        s_address = a;
        exp_rd.push_back(exp);
        @(posedge clk);
        #1;
        s_read = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_aw.size() != 0 || exp_maddr.size() != 0 || exp_aread != 0) && t < 4000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 4000) fail_now("job_timeout");
        repeat (RD_LAT + 4) @(posedge clk);
    endtask

    // Expected transactions of a job, from the high-level rules only.
    task automatic expect_job(input logic [31:0] src, input int count, output logic [31:0] res);
        logic [31:0] sum = 32'b0;
        if (count > 0) exp_aw.push_back('{1'b1, 32'b0});
        for (int i = 0; i < count; i++) begin
            logic [31:0] a = src + 32'(4 * i);
            exp_maddr.push_back(a);
            exp_aw.push_back('{1'b0, mem_word(a)});
            sum = sum + mem_word(a);
        end
        if (count > 0) exp_aread++;
        res = (count > 0) ? (sum ^ KEY) : 32'b0;
    endtask

    task automatic run_job(input logic [31:0] src, input int count, input int stall,
                           input logic [31:0] ctrl, input logic [31:0] exp_status);
        logic [31:0] res;
        stall_cfg = stall;
        expect_job(src, count, res);
        csr_write(2'd1, 32'(count));
        csr_write(2'd0, src);
        csr_write(2'd2, ctrl);
        wait_idle();
        csr_read(2'd2, exp_status);
        csr_read(2'd3, res);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_read"}, 32'(m_read), 32'b0);
        check({tag, "_m_address"}, m_address, 32'b0);
        check({tag, "_a_write"}, 32'(a_write), 32'b0);
        check({tag, "_a_read"}, 32'(a_read), 32'b0);
        check({tag, "_a_address"}, 32'(a_address), 32'b0);
        check({tag, "_a_writedata"}, a_writedata, 32'b0);
        check({tag, "_s_readdata"}, s_readdata, 32'b0);
    endtask

    initial begin
        logic [31:0] res;
        int          base;
        int          t;

        s_address   = 2'b0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = 32'b0;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;
        #2;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // Reset CSR values
        csr_read(2'd0, 32'h0);
        csr_read(2'd1, 32'h0);
        csr_read(2'd2, 32'h0);
        csr_read(2'd3, 32'h0);

        // Directed three-element job
        mem_over[32'h0000_1000] = 32'h3F80_0000;
        mem_over[32'h0000_1004] = 32'h4000_0000;
        mem_over[32'h0000_1008] = 32'h4040_0000;
        run_job(32'h0000_1000, 3, 0, 32'h1, 32'h2);

        // Same job with a 5-cycle waitrequest stall on every read
        run_job(32'h0000_1000, 3, 5, 32'h1, 32'h2);

        // COUNT=0: done within 3 cycles, RESULT cleared, no transactions
        csr_write(2'd1, 32'h0);
        csr_write(2'd2, 32'h1);
        csr_read(2'd2, 32'h2);
        csr_read(2'd3, 32'h0);
        repeat (20) @(posedge clk);

        // Address wraps modulo 2^32
        run_job(32'hFFFF_FFFC, 2, -1, 32'h1, 32'h2);

        // COUNT upper bits read back as 0; CTRL bit1 clears done
        csr_write(2'd1, 32'hABCD_0003);
        csr_read(2'd1, 32'h0000_0003);
        csr_write(2'd2, 32'h2);
        csr_read(2'd2, 32'h0);

        // Start/COUNT/SRC writes during busy are ignored
        spur_en   = 1'b1;
        stall_cfg = -1;
        expect_job(32'h0000_2000, 3, res);
        csr_write(2'd1, 32'd3);
        csr_write(2'd0, 32'h0000_2000);
        csr_write(2'd2, 32'h1);
        repeat (5) @(posedge clk);
        csr_write(2'd1, 32'd7);
        csr_write(2'd0, 32'h0000_5000);
        csr_write(2'd2, 32'h1);
        wait_idle();
        csr_read(2'd2, 32'h2);
        csr_read(2'd3, res);
        csr_read(2'd1, 32'd3);
        csr_read(2'd0, 32'h0000_2000);

        // Randomized jobs
        for (int k = 0; k < 6; k++) begin
            logic [31:0] src;
            src = $urandom & 32'hFFFF_FFFC;
            run_job(src, int'($urandom_range(1, 5)), -1, 32'h1, 32'h2);
        end

`ifdef FEEDER_IRQ_EN
        run_job(32'h0000_0100, 2, -1, 32'h5, 32'h6);
        check("irq_with_done", 32'(irq), 32'h1);
        csr_write(2'd2, 32'h2);
        #1;
        check("irq_cleared", 32'(irq), 32'h0);
        csr_read(2'd2, 32'h0);
`endif

        // Reset pulsed in the GAP after the first data write
        repeat (3) @(posedge clk);
        expect_job(32'h0000_3000, 4, res);
        csr_write(2'd1, 32'd4);
        csr_write(2'd0, 32'h0000_3000);
        csr_write(2'd2, 32'h1);
        base = n_data_wr;
        t    = 0;
        while (n_data_wr == base && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) fail_now("first_push_timeout");
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        exp_aw.delete();
        exp_maddr.delete();
        exp_rd.delete();
        exp_aread = 0;
        pend.delete();
        due_rd    = -100;
        #1;
        check_outputs_zero("midjob_reset");
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (60) @(posedge clk);
        csr_read(2'd0, 32'h0);
        csr_read(2'd1, 32'h0);
        csr_read(2'd2, 32'h0);
        csr_read(2'd3, 32'h0);

        repeat (5) @(posedge clk);
        if (exp_rd.size() != 0) fail_now("csr_reads_not_returned");
        if (exp_aw.size() != 0 || exp_maddr.size() != 0) fail_now("transactions_missing");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/accel_feeder.md
ACCEL_FEEDER -- requirements
Module: accel_feeder

Interface
REQ-001 SHALL have parameter GAP, default 10: minimum clk cycles from one accelerator data write to the next accelerator access.
REQ-002 SHALL have parameter RD_LAT, default 10: cycles from accelerator read strobe to valid a_readdata.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports s_address in 2, s_read in 1, s_write in 1, s_writedata in 32, s_readdata out 32: CPU CSR slave.
REQ-006 SHALL have ports m_address out 32, m_read out 1, m_waitrequest in 1, m_readdata in 32, m_readdatavalid in 1: memory read master.
REQ-007 SHALL have ports a_address out 1, a_write out 1, a_writedata out 32, a_read out 1, a_readdata in 32: accelerator master (addr 0 = data x, addr 1 = arm/clear).

Function
REQ-008 SHALL decode CSR map 0=SRC (32b byte address), 1=COUNT (16b, upper bits read 0), 2=CTRL/STATUS, 3=RESULT (read-only).
REQ-009 SHALL return s_readdata one cycle after s_read; STATUS read = {30'b0, done, busy}.
REQ-010 SHALL start a job on a CTRL write with bit0=1 while idle; busy=1 and done=0 the next cycle.
REQ-011 SHALL ignore start, SRC and COUNT writes while busy=1.
REQ-012 SHALL run FSM IDLE -> ARM -> FETCH -> WAIT_DATA -> PUSH -> GAP -> (FETCH | READ_RES) -> WAIT_RES -> DONE -> IDLE.
REQ-013 ARM SHALL assert a_write for one cycle with a_address=1, a_writedata=0.
REQ-014 FETCH SHALL hold m_read=1 and m_address stable until a cycle where m_waitrequest=0.
REQ-015 WAIT_DATA SHALL capture m_readdata on m_readdatavalid=1; m_readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-016 PUSH SHALL assert a_write for exactly one cycle, a_address=0, a_writedata=captured word.
REQ-017 GAP SHALL last GAP-1 cycles after PUSH before the next accelerator strobe.
REQ-018 The element address SHALL be SRC + 4*i, i = 0..COUNT-1, wrapping modulo 2^32.
REQ-019 After the last GAP, READ_RES SHALL assert a_read for one cycle; WAIT_RES SHALL sample a_readdata exactly RD_LAT cycles after that strobe into RESULT.
REQ-020 DONE SHALL last one cycle: busy=0, done=1; done SHALL stay 1 until the next start or a CTRL write with bit1=1.
REQ-021 COUNT=0 SHALL go directly to DONE with RESULT=0 and no memory or accelerator transactions.
REQ-022 a_write and a_read SHALL never be asserted in the same cycle; m_read SHALL be 0 outside FETCH.

Reset
REQ-023 reset_n=0 SHALL, asynchronously and at any point mid-job, force FSM=IDLE, SRC=0, COUNT=0, RESULT=0, busy=0, done=0, m_read=0, a_write=0, a_read=0, m_address=0, a_address=0, a_writedata=0, s_readdata=0.
REQ-024 After reset release the block SHALL issue no transaction until a start write.

Configuration
REQ-025 With macro FEEDER_IRQ_EN defined: output irq (1b) SHALL exist, CTRL bit2 = irq-enable (read back in STATUS bit2), irq = done AND irq-enable, cleared with done.
REQ-026 Without FEEDER_IRQ_EN: no irq port, CTRL bit2 ignored, STATUS bit2 reads 0; all other behaviour identical.

Verification
REQ-027 SRC=0x1000, COUNT=3, memory {0x3F800000,0x40000000,0x40400000}, start -> one arm write, reads of 0x1000/0x1004/0x1008, three a_write addr0 with those words spaced >=10 cycles, one a_read, RESULT=stub value, STATUS=2.
REQ-028 Same job with m_waitrequest held 5 cycles per read -> m_address and m_read stable throughout stall, identical write sequence.
REQ-029 COUNT=0, start -> STATUS=2 within 3 cycles, RESULT=0, no m_read/a_write/a_read ever asserted.
REQ-030 SRC=0xFFFFFFFC, COUNT=2 -> reads at 0xFFFFFFFC then 0x00000000.
REQ-031 Start during busy, COUNT write during busy -> ignored, job completes with original COUNT; reset_n pulsed mid-GAP -> all outputs 0 immediately, no further strobes.
REQ-032 FEEDER_IRQ_EN defined, CTRL=0x5 -> irq=1 with done; CTRL write 0x2 -> irq=0, done=0.
